// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed byte image into instruction memory, then releases the core.
// Define IMEM_CHECKSUM_EN to require a trailing XOR checksum byte over the data bytes.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              cpu_reset,
    output logic              loading,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    input  logic              overflow_in,
    output logic              overflow_sticky
);
    typedef enum logic [3:0] {
        IDLE, HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, RUN, ERR
`ifdef IMEM_CHECKSUM_EN
        , CHK
`endif
    } state_t;

`ifdef IMEM_CHECKSUM_EN
    localparam state_t fin_st = CHK;
    logic [7:0] chk;
`else
    localparam state_t fin_st = RUN;
`endif
    localparam logic [16:0] capacity = 17'(1) << ADDR_W;

    state_t      state, state_n;
    logic [15:0] n;
    logic [15:0] n_full;
    logic        accept, last;

    assign byte_ready = state inside {HDR_HI, HDR_LO, DATA_HI, DATA_LO}
`ifdef IMEM_CHECKSUM_EN
                        || state == CHK
`endif
                        ;
    assign accept    = byte_valid && byte_ready;
    assign n_full    = {n[15:8], byte_in};
    assign last      = (17'(word_count) + 17'd1) == {1'b0, n};
    assign im_we     = state == WRITE;
    assign cpu_reset = state != RUN;
    assign loading   = !(state inside {IDLE, RUN, ERR});
    assign done      = state == RUN;
    assign error     = state == ERR;

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? HDR_HI : IDLE;
            HDR_HI:  state_n = accept ? HDR_LO : HDR_HI;
            HDR_LO:  if (accept) state_n = n_full == 16'd0 ? fin_st : {1'b0, n_full} > capacity ? ERR : DATA_HI;
            DATA_HI: state_n = accept ? DATA_LO : DATA_HI;
            DATA_LO: state_n = accept ? WRITE : DATA_LO;
            WRITE:   state_n = last ? fin_st : DATA_HI;
`ifdef IMEM_CHECKSUM_EN
            CHK:     if (accept) state_n = byte_in == chk ? RUN : ERR;
`endif
            default: state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n               <= '0;
            im_addr         <= '0;
            im_wdata        <= '0;
            word_count      <= '0;
            overflow_sticky <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            chk             <= '0;
`endif
        end else begin
            if (accept && state == HDR_HI) n[15:8] <= byte_in;
            if (accept && state == HDR_LO) n[7:0] <= byte_in;
            if (accept && state == DATA_HI) im_wdata[15:8] <= byte_in;
            if (accept && state == DATA_LO) im_wdata[7:0] <= byte_in;
`ifdef IMEM_CHECKSUM_EN
            if (accept && (state == DATA_HI || state == DATA_LO)) chk <= chk ^ byte_in;
`endif
            if (state == WRITE) begin
                im_addr    <= im_addr + ADDR_W'(1);
                word_count <= word_count + (ADDR_W+1)'(1);
            end
            if (state == RUN && overflow_in) overflow_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed loads with a write scoreboard and a status queue checked by one monitor.
module tb_imem_boot_loader;
    logic        clk = 0, reset = 1, start = 0, byte_valid = 0, overflow_in = 0;
    logic [7:0]  byte_in = 0;
    logic        byte_ready, im_we, cpu_reset, loading, done, error, overflow_sticky;
    logic [7:0]  im_addr;
    logic [15:0] im_wdata;
    logic [8:0]  word_count;

    imem_boot_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_reset(cpu_reset), .loading(loading), .done(done), .error(error),
        .word_count(word_count), .overflow_in(overflow_in), .overflow_sticky(overflow_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [7:0]  gap;
    } wr_t;

    wr_t         wq[$];
    logic [23:0] sq[$];
    string       sn[$];
    logic [15:0] words[$];
    int          checks = 0, failures = 0, cyc = 0, last_we = 0, timeouts = 0;
    bit          fin = 0;

    function automatic logic [23:0] st(input bit c, l, d, e, r, o, w, input logic [8:0] wc, input logic [7:0] a);
        return {c, l, d, e, r, o, w, wc, a};
    endfunction

    function automatic int rnd(input int m);
        return m == 0 ? 0 : int'($urandom_range(m, 0));
    endfunction

    task automatic expect_st(input string name, input logic [23:0] v);
        sq.push_back(v);
        sn.push_back(name);
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [15:0] d, input logic [7:0] g);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.gap  = g;
        wq.push_back(w);
    endtask

    always @(negedge clk) begin
        wr_t         e;
        logic [23:0] v, a;
        string       nm;
        cyc++;
        if (im_we) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected actual addr=%h data=%h required no write", im_addr, im_wdata);
            end else begin
                e = wq.pop_front();
                if (im_addr !== e.addr || im_wdata !== e.data) begin
                    failures++;
                    $display("FAIL write actual addr=%h data=%h required addr=%h data=%h", im_addr, im_wdata, e.addr, e.data);
                end
                if (e.gap != 0) begin
                    checks++;
                    if (cyc - last_we != int'(e.gap)) begin
                        failures++;
                        $display("FAIL write_spacing actual=%0d required=%0d", cyc - last_we, e.gap);
                    end
                end
            end
            last_we = cyc;
        end
        while (sq.size() > 0) begin
            v  = sq.pop_front();
            nm = sn.pop_front();
            a  = st(cpu_reset, loading, done, error, byte_ready, overflow_sticky, im_we, word_count, im_addr);
            checks++;
            if (a !== v) begin
                failures++;
                $display("FAIL %s actual=%h required=%h (rst,load,done,err,rdy,ovf,we,wc,addr)", nm, a, v);
            end
        end
        if (fin) begin
            checks++;
            if (wq.size() != 0 || timeouts != 0) begin
                failures++;
                $display("FAIL end_state actual pending_writes=%0d timeouts=%0d required 0 and 0", wq.size(), timeouts);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        byte_valid = 0;
        repeat (gap) tick();
        byte_valid = 1;
        byte_in    = b;
        for (int k = 0; k < 50 && !byte_ready; k++) tick();
        if (!byte_ready) timeouts++;
        else tick();
        byte_valid = 0;
    endtask

    task automatic do_reset;
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic wait_end;
        for (int k = 0; k < 2000 && !(done || error); k++) tick();
        if (!(done || error)) timeouts++;
    endtask

    task automatic pulse_start(input logic [7:0] b);
        start      = 1;
        byte_valid = 1;
        byte_in    = b;
        tick();
        start      = 0;
        byte_valid = 0;
    endtask

    task automatic load(input int gmax, input bit gap_chk);
        int n = words.size();
`ifdef IMEM_CHECKSUM_EN
        logic [7:0] x = 0;
`endif
        foreach (words[i]) expect_wr(8'(i), words[i], (gap_chk && i > 0) ? 8'd3 : 8'd0);
        pulse_start(8'(n >> 8));
        expect_st("loading_after_start", st(1, 1, 0, 0, 1, 0, 0, 9'd0, 8'd0));
        send(8'(n >> 8), rnd(gmax));
        send(8'(n), rnd(gmax));
        foreach (words[i]) begin
            send(words[i][15:8], rnd(gmax));
            send(words[i][7:0], rnd(gmax));
`ifdef IMEM_CHECKSUM_EN
            x = x ^ words[i][15:8] ^ words[i][7:0];
`endif
        end
`ifdef IMEM_CHECKSUM_EN
        send(x, rnd(gmax));
`endif
    endtask

    initial begin
        tick();
        tick();
        expect_st("reset_state", st(1, 0, 0, 0, 0, 0, 0, 9'd0, 8'd0));
        reset = 0;
        tick();

        words = '{16'h1234, 16'hABCD};
        load(0, 1);
        wait_end();
        expect_st("two_word_run", st(0, 0, 1, 0, 0, 0, 0, 9'd2, 8'd2));
        overflow_in = 1;
        tick();
        overflow_in = 0;
        expect_st("overflow_set", st(0, 0, 1, 0, 0, 1, 0, 9'd2, 8'd2));
        repeat (3) tick();
        expect_st("overflow_held", st(0, 0, 1, 0, 0, 1, 0, 9'd2, 8'd2));

        do_reset();
        overflow_in = 1;
        tick();
        overflow_in = 0;
        words.delete();
        load(0, 0);
        expect_st("empty_image_run", st(0, 0, 1, 0, 0, 0, 0, 9'd0, 8'd0));

        do_reset();
        pulse_start(8'h01);
        send(8'h01, 0);
        send(8'h01, 0);
        expect_st("header_too_big", st(1, 0, 0, 1, 0, 0, 0, 9'd0, 8'd0));
        pulse_start(8'h00);
        tick();
        expect_st("err_ignores_start", st(1, 0, 0, 1, 0, 0, 0, 9'd0, 8'd0));

        do_reset();
        words = '{16'hDEAD, 16'hBEEF, 16'h0102, 16'hF00D};
        load(3, 0);
        wait_end();
        expect_st("random_valid_run", st(0, 0, 1, 0, 0, 0, 0, 9'd4, 8'd4));

        do_reset();
        expect_wr(8'd0, 16'hAABB, 8'd0);
        pulse_start(8'h00);
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        send(8'h11, 0);
        do_reset();
        expect_st("mid_load_reset", st(1, 0, 0, 0, 0, 0, 0, 9'd0, 8'd0));
        words = '{16'h5566};
        load(0, 0);
        wait_end();
        expect_st("reload_run", st(0, 0, 1, 0, 0, 0, 0, 9'd1, 8'd1));

        do_reset();
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back({8'(i), ~8'(i)});
        load(0, 1);
        wait_end();
        expect_st("full_capacity_run", st(0, 0, 1, 0, 0, 0, 0, 9'h100, 8'd0));

`ifdef IMEM_CHECKSUM_EN
        do_reset();
        expect_wr(8'd0, 16'h1234, 8'd0);
        pulse_start(8'h00);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'h26, 0);
        expect_st("checksum_match", st(0, 0, 1, 0, 0, 0, 0, 9'd1, 8'd1));
        do_reset();
        expect_wr(8'd0, 16'h1234, 8'd0);
        pulse_start(8'h00);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'h27, 0);
        expect_st("checksum_mismatch", st(1, 0, 0, 1, 0, 0, 0, 9'd1, 8'd1));
`endif

        tick();
        fin = 1;
    end
endmodule
